// File: rtl/vai_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing one upstream Tx request channel
// between NUM_PORTS requesters; multi-beat packets are never interleaved.
module vai_tx_arbiter #(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 4,
  parameter int SRC_W      = $clog2(NUM_PORTS)
) (
  input  logic                                  pClk,
  input  logic                                  SoftReset,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_PORTS-1:0]                  req_last,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic                                  up_almfull,
  output logic                                  out_valid,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [SRC_W-1:0]                      out_src,
  output logic                                  out_last,
  output logic                                  err_overlen,
  output logic                                  dbg_state_o,
  output logic [SRC_W-1:0]                      dbg_ptr_o,
  output logic [SRC_W-1:0]                      dbg_owner_o,
  output logic [$clog2(MAX_BEATS+1)-1:0]        dbg_beat_cnt_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int IDX_W = SRC_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Handshake: a beat on port i transfers in the cycle where req_valid[i] and
  // req_ready[i] are both high; at most one ready bit is ever set, never while
  // up_almfull is high. The out_* stage has no ready and issues one cycle later.

  state_t                  state_q, state_d;
  logic [SRC_W-1:0]        ptr_q, ptr_d;
  logic [SRC_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic                    out_last_q, out_last_d;
  logic                    err_q, err_d;

  logic [IDX_W-1:0]        scan_sum;
  logic [SRC_W-1:0]        scan_idx;
  logic [SRC_W-1:0]        pick;
  logic                    pick_found;

  logic [SRC_W-1:0]        grant_idx;
  logic                    grant_any;
  logic                    accept;
  logic                    sel_last;
  logic [CNT_W-1:0]        beat_num;
  logic                    at_max;
  logic                    release_pkt;
  logic                    forced;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] x);
    return (x == SRC_W'(NUM_PORTS - 1)) ? '0 : x + SRC_W'(1);
  endfunction

  // Rotating priority search starting at ptr_q, wrapping at NUM_PORTS-1.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_sum = IDX_W'(ptr_q) + IDX_W'(k);
      if (scan_sum >= IDX_W'(NUM_PORTS)) begin
        scan_sum = scan_sum - IDX_W'(NUM_PORTS);
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  always_comb begin
    grant_idx = pick;
    grant_any = pick_found && !up_almfull;
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      grant_any = !up_almfull;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ready[i] = grant_any && (grant_idx == SRC_W'(i));
    end
  end

  assign accept      = grant_any && req_valid[grant_idx];
  assign sel_last    = req_last[grant_idx];
  assign beat_num    = (state_q == IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
  assign at_max      = (beat_num == CNT_W'(MAX_BEATS));
  assign release_pkt = accept && (sel_last || at_max);
  assign forced      = accept && at_max && !sel_last;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = accept;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    err_d       = err_q | forced;

    if (accept) begin
      out_data_d = req_data[grant_idx];
      out_src_d  = grant_idx;
      // A packet cut off at MAX_BEATS is closed downstream on its last beat.
      out_last_d = sel_last || at_max;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (release_pkt) begin
            ptr_d      = wrap_inc(grant_idx);
            beat_cnt_d = '0;
          end else begin
            state_d    = LOCKED;
            owner_d    = grant_idx;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        // Owner may stall indefinitely; the lock holds until its packet ends.
        if (accept) begin
          beat_cnt_d = beat_num;
          if (release_pkt) begin
            state_d    = IDLE;
            ptr_d      = wrap_inc(owner_q);
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_src        = out_src_q;
  assign out_last       = out_last_q;
  assign err_overlen    = err_q;
  assign dbg_state_o    = (state_q == LOCKED);
  assign dbg_ptr_o      = ptr_q;
  assign dbg_owner_o    = owner_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_vai_tx_arbiter.sv
// Directed bench for vai_tx_arbiter: round robin, packet locking, almost-full
// stalls, over-length release, reset mid-packet and single-port throughput.
module tb_vai_tx_arbiter;

  localparam int N  = 16;
  localparam int DW = 64;

  logic                   pClk = 1'b0;
  logic                   SoftReset;
  logic [N-1:0]           req_valid;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_last;
  logic [N-1:0]           req_ready;
  logic                   up_almfull;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [3:0]             out_src;
  logic                   out_last;
  logic                   err_overlen;
  logic                   dbg_state_o;
  logic [3:0]             dbg_ptr_o;
  logic [3:0]             dbg_owner_o;
  logic [2:0]             dbg_beat_cnt_o;

  int vectors    = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  vai_tx_arbiter #(
    .NUM_PORTS (N),
    .DATA_WIDTH(DW),
    .MAX_BEATS (4)
  ) dut (
    .pClk          (pClk),
    .SoftReset     (SoftReset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .up_almfull    (up_almfull),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_src       (out_src),
    .out_last      (out_last),
    .err_overlen   (err_overlen),
    .dbg_state_o   (dbg_state_o),
    .dbg_ptr_o     (dbg_ptr_o),
    .dbg_owner_o   (dbg_owner_o),
    .dbg_beat_cnt_o(dbg_beat_cnt_o)
  );

  // Clock and reset
  always #5 pClk = ~pClk;

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    up_almfull = 1'b0;
  endtask

  task automatic test_reset();
    SoftReset = 1'b1;
    idle_inputs();
    tick();
    tick();
    SoftReset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
    vectors++; if (out_src !== 4'd0) begin miscompares++; $display("FAIL reset_out_src got %0d want 0", out_src); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %0b want 0", out_last); end
    vectors++; if (err_overlen !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err_overlen); end
    vectors++; if (dbg_state_o !== 1'b0) begin miscompares++; $display("FAIL reset_state got %0b want 0", dbg_state_o); end
    vectors++; if (dbg_ptr_o !== 4'd0) begin miscompares++; $display("FAIL reset_ptr got %0d want 0", dbg_ptr_o); end
    vectors++; if (dbg_beat_cnt_o !== 3'd0) begin miscompares++; $display("FAIL reset_beat_cnt got %0d want 0", dbg_beat_cnt_o); end
    vectors++; if (req_ready !== 16'h0) begin miscompares++; $display("FAIL reset_ready got %h want 0", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_last[i]  = 1'b1;
      req_data[i]  = 64'hA000 + 64'(i);
    end
    for (int c = 0; c < 32; c++) begin
      #1;
      exp_rdy = 16'h0001 << (c % 16);
      vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rr_ready c%0d got %h want %h", c, req_ready, exp_rdy); end
      exp_q.push_back(64'hA000 + 64'(c % 16));
      tick();
      exp_d = exp_q.pop_front();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rr_valid c%0d got %0b want 1", c, out_valid); end
      vectors++; if (out_src !== 4'(c % 16)) begin miscompares++; $display("FAIL rr_src c%0d got %0d want %0d", c, out_src, c % 16); end
      vectors++; if (out_data !== exp_d) begin miscompares++; $display("FAIL rr_data c%0d got %h want %h", c, out_data, exp_d); end
      vectors++; if (out_last !== 1'b1) begin miscompares++; $display("FAIL rr_last c%0d got %0b want 1", c, out_last); end
    end
    idle_inputs();
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_idle_valid got %0b want 0", out_valid); end
    vectors++; if (dbg_ptr_o !== 4'd0) begin miscompares++; $display("FAIL rr_ptr got %0d want 0", dbg_ptr_o); end
  endtask

  task automatic test_lock();
    req_valid[5] = 1'b1;
    req_last[5]  = 1'b1;
    req_data[5]  = 64'h5005;
    for (int b = 1; b <= 4; b++) begin
      req_valid[3] = 1'b1;
      req_last[3]  = (b == 4);
      req_data[3]  = 64'h3000 + 64'(b);
      #1;
      vectors++; if (req_ready !== 16'h0008) begin miscompares++; $display("FAIL lock_ready b%0d got %h want 0008", b, req_ready); end
      tick();
      vectors++; if (out_src !== 4'd3) begin miscompares++; $display("FAIL lock_src b%0d got %0d want 3", b, out_src); end
      vectors++; if (out_data !== 64'h3000 + 64'(b)) begin miscompares++; $display("FAIL lock_data b%0d got %h", b, out_data); end
      vectors++; if (out_last !== (b == 4)) begin miscompares++; $display("FAIL lock_last b%0d got %0b want %0b", b, out_last, (b == 4)); end
      vectors++; if (dbg_state_o !== (b < 4)) begin miscompares++; $display("FAIL lock_state b%0d got %0b want %0b", b, dbg_state_o, (b < 4)); end
    end
    vectors++; if (dbg_ptr_o !== 4'd4) begin miscompares++; $display("FAIL lock_ptr got %0d want 4", dbg_ptr_o); end
    req_valid[3] = 1'b0;
    #1;
    vectors++; if (req_ready !== 16'h0020) begin miscompares++; $display("FAIL lock_next_ready got %h want 0020", req_ready); end
    tick();
    vectors++; if (out_src !== 4'd5 || out_data !== 64'h5005) begin miscompares++; $display("FAIL lock_next_beat got src %0d data %h want 5/5005", out_src, out_data); end
    vectors++; if (dbg_ptr_o !== 4'd6) begin miscompares++; $display("FAIL lock_next_ptr got %0d want 6", dbg_ptr_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_almfull();
    // Idle almost-full: valid request, no accept, ptr unchanged
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b0;
    req_data[2]  = 64'h2001;
    req_valid[4] = 1'b1;
    req_last[4]  = 1'b1;
    req_data[4]  = 64'h4004;
    up_almfull   = 1'b1;
    #1;
    vectors++; if (req_ready !== 16'h0) begin miscompares++; $display("FAIL af_idle_ready got %h want 0", req_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0 || dbg_ptr_o !== 4'd6) begin miscompares++; $display("FAIL af_idle_hold got valid %0b ptr %0d want 0/6", out_valid, dbg_ptr_o); end
    up_almfull = 1'b0;
    for (int b = 1; b <= 2; b++) begin
      req_data[2] = 64'h2000 + 64'(b);
      #1;
      vectors++; if (req_ready !== 16'h0004) begin miscompares++; $display("FAIL af_pre_ready b%0d got %h want 0004", b, req_ready); end
      tick();
      vectors++; if (out_src !== 4'd2 || out_data !== 64'h2000 + 64'(b)) begin miscompares++; $display("FAIL af_pre_beat b%0d got src %0d data %h", b, out_src, out_data); end
    end
    vectors++; if (dbg_state_o !== 1'b1 || dbg_beat_cnt_o !== 3'd2) begin miscompares++; $display("FAIL af_locked got state %0b cnt %0d want 1/2", dbg_state_o, dbg_beat_cnt_o); end
    req_data[2] = 64'h2003;
    up_almfull  = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      vectors++; if (req_ready !== 16'h0) begin miscompares++; $display("FAIL af_stall_ready s%0d got %h want 0", s, req_ready); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL af_stall_valid s%0d got %0b want 0", s, out_valid); end
    end
    up_almfull = 1'b0;
    for (int b = 3; b <= 4; b++) begin
      req_data[2] = 64'h2000 + 64'(b);
      req_last[2] = (b == 4);
      #1;
      vectors++; if (req_ready !== 16'h0004) begin miscompares++; $display("FAIL af_post_ready b%0d got %h want 0004", b, req_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_src !== 4'd2 || out_data !== 64'h2000 + 64'(b)) begin miscompares++; $display("FAIL af_post_beat b%0d got v %0b src %0d data %h", b, out_valid, out_src, out_data); end
      vectors++; if (out_last !== (b == 4)) begin miscompares++; $display("FAIL af_post_last b%0d got %0b", b, out_last); end
    end
    vectors++; if (dbg_state_o !== 1'b0 || dbg_ptr_o !== 4'd3) begin miscompares++; $display("FAIL af_release got state %0b ptr %0d want 0/3", dbg_state_o, dbg_ptr_o); end
    req_valid[2] = 1'b0;
    #1;
    vectors++; if (req_ready !== 16'h0010) begin miscompares++; $display("FAIL af_next_ready got %h want 0010", req_ready); end
    tick();
    vectors++; if (out_src !== 4'd4 || dbg_ptr_o !== 4'd5) begin miscompares++; $display("FAIL af_next got src %0d ptr %0d want 4/5", out_src, dbg_ptr_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_overlen();
    req_valid[7] = 1'b1;
    req_last[7]  = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      req_data[7] = 64'h7000 + 64'(b);
      #1;
      vectors++; if (req_ready !== 16'h0080) begin miscompares++; $display("FAIL ovl_ready b%0d got %h want 0080", b, req_ready); end
      tick();
      vectors++; if (out_src !== 4'd7 || out_data !== 64'h7000 + 64'(b)) begin miscompares++; $display("FAIL ovl_beat b%0d got src %0d data %h", b, out_src, out_data); end
      vectors++; if (out_last !== (b == 4)) begin miscompares++; $display("FAIL ovl_last b%0d got %0b want %0b", b, out_last, (b == 4)); end
      vectors++; if (err_overlen !== (b >= 4)) begin miscompares++; $display("FAIL ovl_err b%0d got %0b want %0b", b, err_overlen, (b >= 4)); end
      vectors++; if (dbg_state_o !== (b != 4)) begin miscompares++; $display("FAIL ovl_state b%0d got %0b want %0b", b, dbg_state_o, (b != 4)); end
    end
    req_valid[7] = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0 || err_overlen !== 1'b1 || dbg_state_o !== 1'b1) begin miscompares++; $display("FAIL ovl_hold got v %0b err %0b state %0b want 0/1/1", out_valid, err_overlen, dbg_state_o); end
  endtask

  task automatic test_reset_mid_lock();
    idle_inputs();
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
    vectors++; if (err_overlen !== 1'b0 || dbg_state_o !== 1'b0) begin miscompares++; $display("FAIL rst_clear got err %0b state %0b want 0/0", err_overlen, dbg_state_o); end
    req_valid[1] = 1'b1;
    req_last[1]  = 1'b0;
    for (int b = 1; b <= 2; b++) begin
      req_data[1] = 64'h1000 + 64'(b);
      #1;
      vectors++; if (req_ready !== 16'h0002) begin miscompares++; $display("FAIL rst_pre_ready b%0d got %h want 0002", b, req_ready); end
      tick();
    end
    vectors++; if (dbg_state_o !== 1'b1 || dbg_beat_cnt_o !== 3'd2 || dbg_owner_o !== 4'd1) begin miscompares++; $display("FAIL rst_locked got state %0b cnt %0d owner %0d", dbg_state_o, dbg_beat_cnt_o, dbg_owner_o); end
    req_data[1]  = 64'h1003;
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b1;
    req_data[0]  = 64'h0AAA;
    SoftReset    = 1'b1;
    tick();
    SoftReset = 1'b0;
    vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_src !== 4'd0 || out_last !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out got v %0b d %h s %0d l %0b want zeros", out_valid, out_data, out_src, out_last); end
    vectors++; if (dbg_state_o !== 1'b0 || dbg_ptr_o !== 4'd0 || dbg_beat_cnt_o !== 3'd0) begin miscompares++; $display("FAIL rst_mid_state got state %0b ptr %0d cnt %0d", dbg_state_o, dbg_ptr_o, dbg_beat_cnt_o); end
    req_last[1] = 1'b1;
    #1;
    vectors++; if (req_ready !== 16'h0001) begin miscompares++; $display("FAIL rst_first_ready got %h want 0001", req_ready); end
    tick();
    vectors++; if (out_src !== 4'd0 || out_data !== 64'h0AAA) begin miscompares++; $display("FAIL rst_first_beat got src %0d data %h", out_src, out_data); end
    #1;
    vectors++; if (req_ready !== 16'h0002) begin miscompares++; $display("FAIL rst_second_ready got %h want 0002", req_ready); end
    tick();
    vectors++; if (out_src !== 4'd1 || out_data !== 64'h1003 || dbg_ptr_o !== 4'd2) begin miscompares++; $display("FAIL rst_second_beat got src %0d data %h ptr %0d", out_src, out_data, dbg_ptr_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_single_port15();
    req_valid[15] = 1'b1;
    req_last[15]  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_data[15] = 64'hF000 + 64'(c);
      #1;
      vectors++; if (req_ready !== 16'h8000) begin miscompares++; $display("FAIL p15_ready c%0d got %h want 8000", c, req_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_src !== 4'd15 || out_data !== 64'hF000 + 64'(c)) begin miscompares++; $display("FAIL p15_beat c%0d got v %0b src %0d data %h", c, out_valid, out_src, out_data); end
      vectors++; if (dbg_ptr_o !== 4'd0) begin miscompares++; $display("FAIL p15_ptr c%0d got %0d want 0", c, dbg_ptr_o); end
    end
    idle_inputs();
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL p15_idle got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_almfull();
    test_overlen();
    test_reset_mid_lock();
    test_single_port15();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
